// File: rtl/ram_miso_ser_if.sv
// ram_miso_ser_if: word-write / bit-stream bus of the ram_miso_ser buffer.
//
// Handshake (data_o side): a bit transfers on a rising edge where
// data_o_valid && data_o_ready. While data_o_valid=1 and data_o_ready=0 the
// producer holds data_o, data_o_valid and data_o_last stable. data_o_last
// is meaningful only together with data_o_valid.
// Write side: wen/wdone are taken only in cycles where wready=1.
interface ram_miso_ser_if #(
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic          wen;
  logic [AW-1:0] waddr;
  logic [5:0]    data_i;
  logic          wdone;
  logic [AW:0]   wcount;
  logic [2:0]    nbpsc;
  logic          wready;
  logic          data_o;
  logic          data_o_valid;
  logic          data_o_ready;
  logic          data_o_last;
  logic          busy;
  logic          dbg_state;   // read FSM state: 0 = IDLE, 1 = STREAM

  modport master (
    output wen, waddr, data_i, wdone, wcount, nbpsc, data_o_ready,
    input  wready, data_o, data_o_valid, data_o_last, busy, dbg_state
  );

  modport slave (
    input  wen, waddr, data_i, wdone, wcount, nbpsc, data_o_ready,
    output wready, data_o, data_o_valid, data_o_last, busy, dbg_state
  );
endinterface

// File: rtl/ram_miso_ser.sv
// ram_miso_ser: word-in / bit-out buffer. Words of up to 6 bits are written
// one per cycle into a bank, the bank is committed, then streamed out one
// bit per cycle (bit 0 of word 0 first) under valid/ready.
// Optional feature macro: RAM_MISO_PINGPONG_EN -- two banks so a new bank
// can be written while the previous one streams. Without it a single bank
// is used and the write side is blocked until that bank has drained.
module ram_miso_ser #(
  parameter int DEPTH = 64
) (
  input  logic           clk,
  input  logic           rstn,
  ram_miso_ser_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef RAM_MISO_PINGPONG_EN
  localparam int   NB = 2;
  localparam logic PP = 1'b1;
`else
  localparam int   NB = 1;
  localparam logic PP = 1'b0;
`endif
  localparam int MAW = $clog2(NB * DEPTH);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  logic [5:0]    mem_q [NB*DEPTH];
  logic          wbank_q, wbank_d;
  logic [1:0]    full_q, full_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [2:0]    nb_q [2];
  logic [2:0]    nb_d [2];

  state_t        state_q, state_d;
  logic          rbank_q, rbank_d;
  logic [AW-1:0] wi_q, wi_d;
  logic [2:0]    bi_q, bi_d;
  logic          dout_q, dout_d;
  logic          vld_q, vld_d;
  logic          last_q, last_d;
  logic          drain_clr;

  logic          wr_en, commit;
  logic [2:0]    nb_norm;
  logic [MAW-1:0] w_idx, r_idx;
  logic [AW-1:0] rd_wi, wi_nx;
  logic [2:0]    bi_nx;
  logic [5:0]    rd_word;
  logic [CW-1:0] cur_cnt;
  logic [2:0]    cur_nb;
  logic          nx_last;

  assign wr_en  = bus.wen & bus.wready;
  assign commit = bus.wdone & bus.wready & (bus.wcount != '0);

  // Clamp bits-per-word into 1..6 so the bit counter never runs past a word.
  always_comb begin
    nb_norm = bus.nbpsc;
    if (bus.nbpsc == 3'd0) nb_norm = 3'd1;
    if (bus.nbpsc == 3'd7) nb_norm = 3'd6;
  end

`ifdef RAM_MISO_PINGPONG_EN
  assign w_idx = {wbank_q, bus.waddr};
  assign r_idx = {rbank_q, rd_wi};
`else
  assign w_idx = bus.waddr;
  assign r_idx = rd_wi;
`endif

  // Word storage: no reset, contents survive rstn.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[w_idx] <= bus.data_i;
  end

  assign cur_cnt = cnt_q[rbank_q];
  assign cur_nb  = nb_q[rbank_q];

  // Next bit position after a handshake; IDLE always reads word 0.
  always_comb begin
    if (bi_q == cur_nb - 3'd1) begin
      bi_nx = 3'd0;
      wi_nx = wi_q + 1'b1;
    end else begin
      bi_nx = bi_q + 3'd1;
      wi_nx = wi_q;
    end
    rd_wi   = (state_q == IDLE) ? '0 : wi_nx;
    nx_last = ({1'b0, wi_nx} == cur_cnt - 1'b1) && (bi_nx == cur_nb - 3'd1);
  end

  assign rd_word = mem_q[r_idx];

  // Read FSM next state and next registered outputs.
  always_comb begin
    state_d   = state_q;
    rbank_d   = rbank_q;
    wi_d      = wi_q;
    bi_d      = bi_q;
    dout_d    = dout_q;
    vld_d     = vld_q;
    last_d    = last_q;
    drain_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rbank_q]) begin
          wi_d    = '0;
          bi_d    = 3'd0;
          dout_d  = rd_word[0];
          vld_d   = 1'b1;
          last_d  = (cur_cnt == CW'(1)) && (cur_nb == 3'd1);
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (bus.data_o_ready) begin
          if (last_q) begin
            drain_clr = 1'b1;
            rbank_d   = rbank_q ^ PP;
            vld_d     = 1'b0;
            last_d    = 1'b0;
            state_d   = IDLE;
          end else begin
            wi_d   = wi_nx;
            bi_d   = bi_nx;
            dout_d = rd_word[bi_nx];
            last_d = nx_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read FSM with its registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rbank_q <= 1'b0;
      wi_q    <= '0;
      bi_q    <= 3'd0;
      dout_q  <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rbank_q <= rbank_d;
      wi_q    <= wi_d;
      bi_q    <= bi_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  // Bank bookkeeping: a drain clear and a commit of the other bank may share an edge.
  always_comb begin
    full_d  = full_q;
    cnt_d   = cnt_q;
    nb_d    = nb_q;
    wbank_d = wbank_q;
    if (drain_clr) full_d[rbank_q] = 1'b0;
    if (commit) begin
      full_d[wbank_q] = 1'b1;
      cnt_d[wbank_q]  = bus.wcount;
      nb_d[wbank_q]   = nb_norm;
      wbank_d         = wbank_q ^ PP;
    end
  end

  // Bank state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_q  <= 2'b00;
      wbank_q <= 1'b0;
      cnt_q   <= '{default: '0};
      nb_q    <= '{default: '0};
    end else begin
      full_q  <= full_d;
      wbank_q <= wbank_d;
      cnt_q   <= cnt_d;
      nb_q    <= nb_d;
    end
  end

  assign bus.wready       = ~full_q[wbank_q];
  assign bus.data_o       = dout_q;
  assign bus.data_o_valid = vld_q;
  assign bus.data_o_last  = last_q;
  assign bus.busy         = (|full_q) | (state_q == STREAM);
  assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_ram_miso_ser.sv
// tb_ram_miso_ser: directed bench for ram_miso_ser with an expected-bit
// queue filled at commit time and a monitor that pops on every handshake.
module tb_ram_miso_ser;
  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);
`ifdef RAM_MISO_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ram_miso_ser_if #(.DEPTH(DEPTH)) bus ();
  ram_miso_ser #(.DEPTH(DEPTH)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] exp_q[$];          // {last, bit}
  bit         rdy_mode = 1'b0;   // 0: ready always high, 1: random
  logic [5:0] wbuf [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- consumer ready driver ----------------
  always @(posedge clk) begin
    #1;
    bus.data_o_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  logic p_stall, p_last_hs, p_dout, p_vld, p_last;
  always @(negedge clk) begin
    logic [1:0] e;
    if (!rstn) begin
      p_stall   = 1'b0;
      p_last_hs = 1'b0;
    end else begin
      if (p_last_hs) check("gap_after_last", bus.data_o_valid, 1'b0);
      if (p_stall) begin
        check("stall_data",  bus.data_o,       p_dout);
        check("stall_valid", bus.data_o_valid, p_vld);
        check("stall_last",  bus.data_o_last,  p_last);
      end
      if (bus.data_o_valid && bus.data_o_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("data_o",      bus.data_o,      e[0]);
          check("data_o_last", bus.data_o_last, e[1]);
        end
      end
      p_stall   = bus.data_o_valid && !bus.data_o_ready;
      p_last_hs = bus.data_o_valid && bus.data_o_ready && bus.data_o_last;
      p_dout    = bus.data_o;
      p_vld     = bus.data_o_valid;
      p_last    = bus.data_o_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [5:0] d);
    bus.wen    = 1'b1;
    bus.waddr  = AW'(a);
    bus.data_i = d;
    wbuf[a]    = d;
    tick();
    bus.wen = 1'b0;
  endtask

  task automatic commit(input int cnt, input int nb);
    bus.wdone  = 1'b1;
    bus.wcount = (AW+1)'(cnt);
    bus.nbpsc  = 3'(nb);
    tick();
    bus.wdone = 1'b0;
  endtask

  // Hand-computed bit vector, bit 0 leaves first.
  task automatic push_bits(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'(i == n-1), v[i]});
  endtask

  // Serialise the first n words of wbuf, LSB first, eff bits per word.
  task automatic push_model(input int n, input int nb);
    int eff;
    eff = (nb == 0) ? 1 : (nb == 7) ? 6 : nb;
    for (int w = 0; w < n; w++)
      for (int b = 0; b < eff; b++)
        exp_q.push_back({1'((w == n-1) && (b == eff-1)), wbuf[w][b]});
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.busy) && k < 3000) begin
      tick();
      k++;
    end
    check(name, 32'(k < 3000), 32'd1);
    tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int   bad, k;
    logic prev_wr;
    bus.wen = 1'b0; bus.waddr = '0; bus.data_i = '0;
    bus.wdone = 1'b0; bus.wcount = '0; bus.nbpsc = '0;
    bus.data_o_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_wready", bus.wready, 1'b1);
    check("rst_valid",  bus.data_o_valid, 1'b0);
    check("rst_busy",   bus.busy, 1'b0);
    check("rst_data_o", bus.data_o, 1'b0);
    check("rst_last",   bus.data_o_last, 1'b0);
    rstn = 1'b1;
    tick();

    // basic stream: 0x15, 0x2A -> 1,0,1,0,1,0, 0,1,0,1,0,1
    write_word(0, 6'h15);
    write_word(1, 6'h2A);
    push_bits(64'b1010_1001_0101, 12);
    commit(2, 6);
    check("commit_valid_lat0", bus.data_o_valid, 1'b0);
    check("commit_busy",       bus.busy, 1'b1);
    check("commit_wready",     bus.wready, PP);
    tick();
    check("commit_valid_lat1", bus.data_o_valid, 1'b1);
    wait_drain("drain_basic");

    // nbpsc=2, word 0x3D -> 1,0
    write_word(0, 6'h3D);
    push_bits(64'b01, 2);
    commit(1, 2);
    wait_drain("drain_nb2");

    // nbpsc=0 treated as 1 -> 1
    push_bits(64'b1, 1);
    commit(1, 0);
    wait_drain("drain_nb0");

    // nbpsc=7 treated as 6 on three words -> 18 bits
    write_word(0, 6'h01);
    write_word(1, 6'h3E);
    write_word(2, 6'h2B);
    push_bits(64'b101011_111110_000001, 18);
    commit(3, 7);
    wait_drain("drain_nb7");

    // backpressure with random ready
    rdy_mode = 1'b1;
    write_word(0, 6'h2C);
    write_word(1, 6'h13);
    write_word(2, 6'h3F);
    write_word(3, 6'h05);
    push_model(4, 5);
    commit(4, 5);
    wait_drain("drain_backpressure");
    rdy_mode = 1'b0;
    tick();

    // wcount=0 commit is ignored
    write_word(0, 6'h3F);
    commit(0, 6);
    check("wcount0_wready", bus.wready, 1'b1);
    check("wcount0_busy",   bus.busy, 1'b0);
    tick();
    tick();
    check("wcount0_valid",  bus.data_o_valid, 1'b0);

    // wen while wready=0 must not touch the streaming bank
    write_word(0, 6'h0F);
    write_word(1, 6'h30);
    push_model(2, 6);
    commit(2, 6);
    if (PP) begin
      write_word(0, 6'h21);
      write_word(1, 6'h12);
      push_model(2, 6);
      commit(2, 6);
    end
    check("blocked_wready", bus.wready, 1'b0);
    bus.wen = 1'b1; bus.waddr = AW'(0); bus.data_i = 6'h00;
    tick();
    bus.waddr = AW'(1); bus.data_i = 6'h3F;
    tick();
    bus.wen = 1'b0;
    wait_drain("drain_blocked_wen");

`ifdef RAM_MISO_PINGPONG_EN
    // ping-pong: bank 1 written while bank 0 streams
    for (int i = 0; i < DEPTH; i++) write_word(i, 6'((i*7 + 3) & 63));
    push_model(DEPTH, 6);
    commit(DEPTH, 6);
    for (int i = 0; i < DEPTH; i++) write_word(i, 6'((i*5 + 11) & 63));
    push_model(DEPTH, 6);
    commit(DEPTH, 6);
    check("pp_wready_after_2nd", bus.wready, 1'b0);
    k = 0;
    prev_wr = bus.wready;
    while (exp_q.size() > DEPTH*6 && k < 2000) begin
      prev_wr = bus.wready;
      tick();
      k++;
    end
    check("pp_wready_before_drain", prev_wr, 1'b0);
    check("pp_wready_at_drain", bus.wready, 1'b1);
    wait_drain("drain_pingpong");
`else
    // single bank: wready stays low through the whole drain
    for (int i = 0; i < 8; i++) write_word(i, 6'((i*9 + 4) & 63));
    push_model(8, 6);
    commit(8, 6);
    bad = 0;
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      if (bus.wready) bad++;
      tick();
      k++;
    end
    check("single_wready_held", bad, 0);
    check("single_wready_after", bus.wready, 1'b1);
    wait_drain("drain_single");
`endif

    // reset mid-stream
    write_word(0, 6'h11);
    write_word(1, 6'h22);
    write_word(2, 6'h33);
    write_word(3, 6'h0C);
    push_model(4, 6);
    commit(4, 6);
    repeat (6) tick();
    rstn = 1'b0;
    #1;
    check("midrst_valid",  bus.data_o_valid, 1'b0);
    check("midrst_busy",   bus.busy, 1'b0);
    check("midrst_wready", bus.wready, 1'b1);
    exp_q.delete();
    tick();
    tick();
    rstn = 1'b1;
    tick();
    // 0x2D -> 1,0,1,1,0,1 ; 0x12 -> 0,1,0,0,1,0
    write_word(0, 6'h2D);
    write_word(1, 6'h12);
    push_bits(64'b010010_101101, 12);
    commit(2, 6);
    wait_drain("drain_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_miso_ser.md
# ram_miso_ser

Multiple-input single-output bit buffer for the OFDM TX datapath. It stores per-subcarrier words of up to 6 bits, written one word per cycle. It then streams each committed bank back out one bit per cycle under a valid/ready handshake. It is the word-in/bit-out counterpart of the bit-in/word-out interleaver RAM, and is used where grouped coded bits must be re-serialised, such as scrambler/CRC re-check paths and bit-level debug taps.

## Interface
Parameters:
- DEPTH, 64, words per bank; power of two, at least 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- wen  in  1  word write strobe; ignored while wready=0.
- waddr  in  $clog2(DEPTH)  word address inside the current write bank.
- data_i  in  6  word; bit 0 is the first bit serialised.
- wdone  in  1  commit current write bank; ignored while wready=0.
- wcount  in  $clog2(DEPTH)+1  words in the bank, sampled with wdone; valid range 1..DEPTH.
- nbpsc  in  3  bits per word, sampled with wdone; 0 is treated as 1, 7 is treated as 6.
- wready  out  1  current write bank is free.
- data_o  out  1  serial bit.
- data_o_valid  out  1  data_o holds a valid bit.
- data_o_ready  in  1  consumer accepts data_o this cycle.
- data_o_last  out  1  last bit of the bank; qualified by data_o_valid.
- busy  out  1  any bank is full or streaming.

## Operation
- Storage: 2 banks x DEPTH x 6 bits, unregistered word read.
- Per-bank registers: full flag, count, nbpsc.
- Write side:
  - wbank pointer; wready = !full[wbank].
  - wen&&wready writes data_i to mem[wbank][waddr].
  - wdone&&wready with wcount!=0 latches count and nbpsc, sets full[wbank], and toggles wbank.
  - wdone with wcount=0 is ignored.
  - wen and wdone in the same cycle: the write lands in the bank being committed.
- Read FSM, with states IDLE and STREAM; registers rbank, word index wi, bit index bi.
  - IDLE: if full[rbank], load bit 0 of word 0 into data_o, set wi=bi=0, assert data_o_valid, go to STREAM.
  - STREAM:
    - data_o, data_o_valid and data_o_last hold stable while data_o_ready=0.
    - On handshake, if bi<nbpsc-1, increment bi. Otherwise set bi=0 and increment wi.
    - data_o then takes the next bit.
    - data_o_last=1 when wi=count-1 and bi=nbpsc-1.
    - On handshake with data_o_last: clear full[rbank], toggle rbank, drop data_o_valid, go to IDLE.
- There is always exactly one idle cycle between banks.
- Serialised bits beyond nbpsc in a word are never output.
- busy = full[0]|full[1]|(state==STREAM).
- Reset values: wbank=rbank=0, full=0, state=IDLE, wready=1, data_o=0, data_o_valid=0, data_o_last=0, busy=0. Memory is not cleared.
- Reset mid-stream aborts immediately; a partially output bank is discarded.

## Timing
- Write: wen at edge N makes the word readable at edge N+1.
- Commit: wdone sampled at edge N sets full at N. data_o_valid is high from edge N+1, with the bank's first bit on data_o.
- wready falls at edge N when the commit fills the last free bank.
- Throughput: one bit per cycle while data_o_ready=1.
- Drain: the final handshake at edge M clears full (wready may rise at M) and drops data_o_valid. The next bank's first bit is valid from M+1 at the earliest.
- A commit of bank A and a drain-clear of bank B on the same edge are both honoured.

## Configuration
- RAM_MISO_PINGPONG_EN defined: two banks as described; write of bank B overlaps streaming of bank A.
- Not defined:
  - Single bank; wbank and rbank are fixed at 0.
  - wready=0 from the commit edge until the final handshake edge of that bank.
  - Storage is DEPTH x 6 bits.

## Test plan
- Reset then idle: wready=1, data_o_valid=0, busy=0, data_o=0.
- Basic stream:
  - Stimulus: write words 0x15,0x2A; commit with wcount=2, nbpsc=6; hold data_o_ready=1.
  - Response: data_o_valid rises one edge after commit. Bits 1,0,1,0,1,0,0,1,0,1,0,1 come out over 12 cycles. data_o_last is high only on the 12th bit, then there is one idle cycle.
- nbpsc handling:
  - nbpsc=2, word 0x3D gives bits 1,0.
  - nbpsc=0 gives bit 1 only (treated as 1).
  - nbpsc=7 on a 3-word bank gives 18 bits.
- Backpressure: toggle data_o_ready randomly; data_o, data_o_valid and data_o_last are held stable on every stalled cycle, and the sequence matches the unstalled reference.
- Ping-pong (macro defined):
  - Commit bank 0 with 64 words, then bank 1 with 64 words while bank 0 streams. wready=0 after the second commit and rises on the edge bank 0 drains.
  - Macro undefined: wready=0 through the whole drain.
- Boundaries:
  - wcount=0 commit is ignored (wready and full unchanged).
  - wen while wready=0 does not corrupt the streaming bank.
  - rstn low mid-stream forces data_o_valid=0 immediately; after release, the next commit streams from its word 0.
